// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: SR/Cause/EPC/PRId, req decision, mfc0/mtc0, eret.
// Optional build macro CP0_INT_STICKY_EN makes Cause.IP latch pending interrupt pulses until serviced.
module cp0_exc_ctrl #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL   = 32'h2020_0701
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [4:0]  exc_code_m,
   input  logic        eret_m,
   input  logic [5:0]  hw_int,
   output logic [31:0] rdata,
   output logic [31:0] epc_out,
   output logic        req,
   output logic [31:0] handler_pc,
   output logic        exl
);

   localparam int unsigned IM_W   = 6;
   localparam int unsigned CODE_W = 5;

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [IM_W-1:0]   im;
   logic              ie;
   logic              exl_q;
   logic              bd;
   logic [IM_W-1:0]   ip;
   logic [CODE_W-1:0] exc_code;
   logic [31:0]       epc;

   logic              int_req;
   logic              exc_req;
   logic [IM_W-1:0]   ip_next;
   logic [31:0]       epc_take;

   assign int_req  = ie & ~exl_q & (|(ip & im));
   assign exc_req  = (exc_code_m != 5'd0) & ~exl_q;
   assign req      = int_req | exc_req;
   assign epc_take = (bd_m ? (pc_m - 32'd4) : pc_m) & 32'hFFFF_FFFC;

`ifdef CP0_INT_STICKY_EN
   // Serviced (enabled) bits drop on the taking edge; new pin activity is still merged in.
   assign ip_next = (int_req ? (ip & ~im) : ip) | hw_int;
`else
   assign ip_next = hw_int;
`endif

   // CP0 state; req dominates mtc0 and eret, eret's EXL clear dominates an SR write.
   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         ie       <= 1'b0;
         exl_q    <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= ip_next;
         if (req) begin
            exl_q    <= 1'b1;
            exc_code <= int_req ? CODE_W'(0) : exc_code_m;
            bd       <= bd_m;
            epc      <= epc_take;
         end else begin
            if (we && addr == ADDR_SR) begin
               im    <= wdata[15:10];
               exl_q <= wdata[1];
               ie    <= wdata[0];
            end
            if (we && addr == ADDR_EPC) begin
               epc <= wdata & 32'hFFFF_FFFC;
            end
            if (eret_m) begin
               exl_q <= 1'b0;
            end
         end
      end
   end

   // mfc0 read mux, zero-latency
   always_comb begin
      rdata = 32'd0;
      case (addr)
         ADDR_SR:    rdata = {16'd0, im, 8'd0, exl_q, ie};
         ADDR_CAUSE: rdata = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
         ADDR_EPC:   rdata = epc;
         ADDR_PRID:  rdata = PRID_VAL;
         default:    rdata = 32'd0;
      endcase
   end

   assign epc_out    = epc;
   assign exl        = exl_q;
   assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl; sticky-IP expectations follow CP0_INT_STICKY_EN.
module tb_cp0_exc_ctrl;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] pc_m;
   logic        bd_m;
   logic [4:0]  exc_code_m;
   logic        eret_m;
   logic [5:0]  hw_int;
   logic [31:0] rdata;
   logic [31:0] epc_out;
   logic        req;
   logic [31:0] handler_pc;
   logic        exl;

   int n_checks;
   int n_fail;

   cp0_exc_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .pc_m       (pc_m),
      .bd_m       (bd_m),
      .exc_code_m (exc_code_m),
      .eret_m     (eret_m),
      .hw_int     (hw_int),
      .rdata      (rdata),
      .epc_out    (epc_out),
      .req        (req),
      .handler_pc (handler_pc),
      .exl        (exl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change 1 time unit after the rising edge; outputs are checked 1 unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; addr = 5'd0; wdata = 32'd0; pc_m = 32'd0; bd_m = 1'b0;
      exc_code_m = 5'd0; eret_m = 1'b0; hw_int = 6'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      step();
      we = 1'b0; wdata = 32'd0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
      n_checks++; if (exl !== 1'b0) begin n_fail++; $display("FAIL reset_exl: got %b want 0", exl); end
      n_checks++; if (epc_out !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc_out); end
      n_checks++; if (handler_pc !== 32'h0000_4180) begin n_fail++; $display("FAIL handler_pc: got %h want 00004180", handler_pc); end
      addr = 5'd15; #1;
      n_checks++; if (rdata !== 32'h2020_0701) begin n_fail++; $display("FAIL prid_read: got %h want 20200701", rdata); end
      addr = 5'd12; #1;
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_sr: got %h want 0", rdata); end
      addr = 5'd13; #1;
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_cause: got %h want 0", rdata); end
      addr = 5'd7; #1;
      n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL other_addr: got %h want 0", rdata); end
   endtask

   task automatic test_interrupt();
      do_reset();
      // IE=1 and IM bit for hw_int[2] (SR[12])
      mtc0(5'd12, 32'h0000_1001);
      addr = 5'd12; #1;
      n_checks++; if (rdata !== 32'h0000_1001) begin n_fail++; $display("FAIL sr_write: got %h want 00001001", rdata); end
      pc_m = 32'h3010; bd_m = 1'b0; hw_int = 6'b000100; #1;
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL int_before_ip: got %b want 0", req); end
      step();
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL int_req: got %b want 1", req); end
      step();
      n_checks++; if (exl !== 1'b1) begin n_fail++; $display("FAIL int_exl: got %b want 1", exl); end
      n_checks++; if (epc_out !== 32'h3010) begin n_fail++; $display("FAIL int_epc: got %h want 00003010", epc_out); end
      addr = 5'd13; #1;
      n_checks++; if (rdata !== 32'h0000_1000) begin n_fail++; $display("FAIL int_cause: got %h want 00001000", rdata); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL int_masked_after[%0d]: got %b want 0", i, req); end
         step();
      end
      hw_int = 6'd0;
   endtask

   task automatic test_delay_slot();
      do_reset();
      exc_code_m = 5'd4; pc_m = 32'h3024; bd_m = 1'b1; #1;
      n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL ds_req: got %b want 1", req); end
      step();
      exc_code_m = 5'd0; bd_m = 1'b0; pc_m = 32'h3028; #1;
      n_checks++; if (epc_out !== 32'h3020) begin n_fail++; $display("FAIL ds_epc: got %h want 00003020", epc_out); end
      addr = 5'd13; #1;
      n_checks++; if (rdata !== 32'h8000_0010) begin n_fail++; $display("FAIL ds_cause: got %h want 80000010", rdata); end
      n_checks++; if (exl !== 1'b1) begin n_fail++; $display("FAIL ds_exl: got %b want 1", exl); end
   endtask

   // runs from the EXL=1 state left by test_delay_slot
   task automatic test_eret();
      eret_m = 1'b1;
      step();
      eret_m = 1'b0; #1;
      n_checks++; if (exl !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %b want 0", exl); end
      n_checks++; if (epc_out !== 32'h3020) begin n_fail++; $display("FAIL eret_epc: got %h want 00003020", epc_out); end
      addr = 5'd13; #1;
      n_checks++; if (rdata !== 32'h8000_0010) begin n_fail++; $display("FAIL eret_cause: got %h want 80000010", rdata); end
   endtask

   task automatic test_masking();
      do_reset();
      exc_code_m = 5'd5; pc_m = 32'h3100;
      step();
      exc_code_m = 5'd10; pc_m = 32'h3200; #1;
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL mask_exl_req: got %b want 0", req); end
      step();
      exc_code_m = 5'd0; #1;
      n_checks++; if (epc_out !== 32'h3100) begin n_fail++; $display("FAIL mask_epc: got %h want 00003100", epc_out); end
      addr = 5'd13; #1;
      n_checks++; if (rdata !== 32'h0000_0014) begin n_fail++; $display("FAIL mask_cause: got %h want 00000014", rdata); end
      do_reset();
      mtc0(5'd12, 32'h0000_1000);
      hw_int = 6'b000100;
      step();
      step();
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL mask_ie_req: got %b want 0", req); end
      n_checks++; if (exl !== 1'b0) begin n_fail++; $display("FAIL mask_ie_exl: got %b want 0", exl); end
      hw_int = 6'd0;
   endtask

   task automatic test_collision();
      do_reset();
      we = 1'b1; addr = 5'd14; wdata = 32'h5555; exc_code_m = 5'd12; pc_m = 32'h3040;
      step();
      we = 1'b0; exc_code_m = 5'd0; #1;
      n_checks++; if (epc_out !== 32'h3040) begin n_fail++; $display("FAIL coll_epc: got %h want 00003040", epc_out); end
      addr = 5'd13; #1;
      n_checks++; if (rdata !== 32'h0000_0030) begin n_fail++; $display("FAIL coll_cause: got %h want 00000030", rdata); end
      eret_m = 1'b1;
      step();
      eret_m = 1'b0;
      mtc0(5'd14, 32'h3007);
      addr = 5'd14; #1;
      n_checks++; if (rdata !== 32'h3004) begin n_fail++; $display("FAIL epc_write: got %h want 00003004", rdata); end
      mtc0(5'd13, 32'hFFFF_FFFF);
      addr = 5'd13; #1;
      n_checks++; if (rdata !== 32'h0000_0030) begin n_fail++; $display("FAIL cause_ro: got %h want 00000030", rdata); end
      // SR write requesting EXL=1 together with eret: EXL ends 0, IE/IM still written
      we = 1'b1; addr = 5'd12; wdata = 32'h0000_1003; eret_m = 1'b1;
      step();
      we = 1'b0; eret_m = 1'b0; #1;
      n_checks++; if (rdata !== 32'h0000_1001) begin n_fail++; $display("FAIL sr_eret: got %h want 00001001", rdata); end
   endtask

   task automatic test_sticky();
      logic exp_req;
`ifdef CP0_INT_STICKY_EN
      exp_req = 1'b1;
`else
      exp_req = 1'b0;
`endif
      do_reset();
      mtc0(5'd12, 32'h0000_1001);
      exc_code_m = 5'd3; pc_m = 32'h3300;
      step();
      exc_code_m = 5'd0; hw_int = 6'b000100;
      step();
      hw_int = 6'd0;
      step();
      n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL sticky_masked: got %b want 0", req); end
      eret_m = 1'b1;
      step();
      eret_m = 1'b0; #1;
      n_checks++; if (exl !== 1'b0) begin n_fail++; $display("FAIL sticky_eret_exl: got %b want 0", exl); end
      n_checks++; if (req !== exp_req) begin n_fail++; $display("FAIL sticky_req: got %b want %b", req, exp_req); end
      step();
      n_checks++; if (exl !== exp_req) begin n_fail++; $display("FAIL sticky_taken_exl: got %b want %b", exl, exp_req); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle_inputs();
      test_reset();
      test_interrupt();
      test_delay_slot();
      test_eret();
      test_masking();
      test_collision();
      test_sticky();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
